// File: rtl/y_stream_deserializer.sv
// Serial-to-parallel collector for the sequence generator's y_out stream.
// Words are assembled LSB first and held in a single-entry output buffer with a sticky overrun flag.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  EMPTY | no undelivered word; a completion loads the output register
//  FULL  | word_out/ones_count hold a word awaiting word_ready
module y_stream_deserializer #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             word_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] word_out,
    output logic [CW-1:0]    ones_count,
    output logic             word_valid,
    output logic             overrun,
    output logic [CW-1:0]    bit_index
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [CW-1:0] LAST_INDEX = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    part_cnt;

    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] word_next;
    logic [CW-1:0]    cnt_next;
    logic             complete;
    logic             overrun_set;

    // Positions above bit_index are always zero, so OR-ing in the new bit is enough.
    always_comb begin
        bit_mask    = WIDTH'(1) << bit_index;
        word_next   = bit_in ? (shift_reg | bit_mask) : shift_reg;
        cnt_next    = part_cnt + CW'(bit_in);
        complete    = bit_valid && (bit_index == LAST_INDEX);
        overrun_set = (state == FULL) && !word_ready && complete;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= EMPTY;
            shift_reg  <= '0;
            part_cnt   <= '0;
            bit_index  <= '0;
            word_out   <= '0;
            ones_count <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (bit_valid) begin
                if (complete) begin
                    shift_reg <= '0;
                    part_cnt  <= '0;
                    bit_index <= '0;
                end else begin
                    shift_reg <= word_next;
                    part_cnt  <= cnt_next;
                    bit_index <= bit_index + CW'(1);
                end
            end

            case (state)
                EMPTY: begin
                    if (complete) begin
                        word_out   <= word_next;
                        ones_count <= cnt_next;
                        word_valid <= 1'b1;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    // Accept and completion in one cycle swap words without a bubble.
                    if (word_ready && complete) begin
                        word_out   <= word_next;
                        ones_count <= cnt_next;
                    end else if (word_ready) begin
                        word_valid <= 1'b0;
                        state      <= EMPTY;
                    end
                end
                default: begin
                    word_valid <= 1'b0;
                    state      <= EMPTY;
                end
            endcase

            if (overrun_set)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_y_stream_deserializer.sv
// Directed and randomized checks of y_stream_deserializer against a queue-based word model.
module tb_y_stream_deserializer;

    localparam int WIDTH = 8;
    localparam int CW = $clog2(WIDTH + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             word_ready = 1'b0;
    logic             clr_overrun = 1'b0;
    logic [WIDTH-1:0] word_out;
    logic [CW-1:0]    ones_count;
    logic             word_valid;
    logic             overrun;
    logic [CW-1:0]    bit_index;

    y_stream_deserializer #(.WIDTH(WIDTH)) dut (
        .clock(clock),
        .reset(reset),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .word_ready(word_ready),
        .clr_overrun(clr_overrun),
        .word_out(word_out),
        .ones_count(ones_count),
        .word_valid(word_valid),
        .overrun(overrun),
        .bit_index(bit_index)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: collected bits in a queue, delivered word as plain values.
    logic       m_bits[$];
    logic [31:0] m_word = 0;
    int         m_cnt = 0;
    logic       m_valid = 0;
    logic       m_ovr = 0;
    int         valid_cycles = 0;
    int         captured_cnt[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_edge(input logic bv, input logic bi, input logic wr,
                              input logic clr, input logic rst);
        logic        done;
        logic [31:0] w;
        done = 1'b0;
        w = 0;
        if (rst) begin
            m_bits.delete();
            m_word = 0;
            m_cnt = 0;
            m_valid = 0;
            m_ovr = 0;
            return;
        end
        if (bv) begin
            m_bits.push_back(bi);
            if (m_bits.size() == WIDTH) begin
                for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || wr) begin
                m_valid = 1;
                m_word = w;
                m_cnt = $countones(w);
                if (!clr) m_ovr = m_ovr;
                else m_ovr = 0;
            end else begin
                m_ovr = 1;
            end
        end else begin
            if (m_valid && wr) m_valid = 0;
            if (clr) m_ovr = 0;
        end
    endtask

    task automatic check_all();
        chk("word_valid", 32'(word_valid), 32'(m_valid));
        chk("word_out", 32'(word_out), m_word);
        chk("ones_count", 32'(ones_count), 32'(m_cnt));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("bit_index", 32'(bit_index), 32'(m_bits.size()));
        if (word_valid) chk("popcount", 32'(ones_count), 32'($countones(word_out)));
    endtask

    task automatic step(input logic bv, input logic bi, input logic wr,
                        input logic clr, input logic rst);
        bit_valid = bv;
        bit_in = bi;
        word_ready = wr;
        clr_overrun = clr;
        reset = rst;
        @(posedge clock);
        model_edge(bv, bi, wr, clr, rst);
        #1;
        check_all();
        if (word_valid) begin
            valid_cycles++;
            captured_cnt.push_back(int'(ones_count));
        end
    endtask

    task automatic send_word(input logic [7:0] w, input logic wr, input logic gapped);
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b1, w[i], wr, 1'b0, 1'b0);
            if (gapped && i < WIDTH - 1) step(1'b0, 1'b0, wr, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_word", 32'(word_out), 32'h0);
        chk("reset_valid", 32'(word_valid), 32'h0);

        // Consecutive bits 1,0,1,1,0,0,0,1 -> 8'h8D
        send_word(8'h8D, 1'b0, 1'b0);
        chk("t1_word", 32'(word_out), 32'h8D);
        chk("t1_cnt", 32'(ones_count), 32'd4);
        chk("t1_valid", 32'(word_valid), 32'd1);

        // Gapped valid gives the same word
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h8D, 1'b0, 1'b1);
        chk("t2_word", 32'(word_out), 32'h8D);
        chk("t2_cnt", 32'(ones_count), 32'd4);

        // Overrun while the first word is held
        send_word(8'hFF, 1'b0, 1'b0);
        chk("t3_word_kept", 32'(word_out), 32'h8D);
        chk("t3_overrun", 32'(overrun), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_accept", 32'(word_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_clear", 32'(overrun), 32'd0);

        // Overrun set wins over a simultaneous clear
        send_word(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("set_wins", 32'(overrun), 32'd1);
        chk("set_wins_word", 32'(word_out), 32'h3C);

        // Continuous stream with word_ready held high
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        valid_cycles = 0;
        captured_cnt.delete();
        send_word(8'hFF, 1'b1, 1'b0);
        send_word(8'h00, 1'b1, 1'b0);
        send_word(8'hA5, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_pulses", 32'(valid_cycles), 32'd3);
        chk("t4_cnt0", 32'(captured_cnt[0]), 32'd8);
        chk("t4_cnt1", 32'(captured_cnt[1]), 32'd0);
        chk("t4_cnt2", 32'(captured_cnt[2]), 32'd4);
        chk("t4_no_ovr", 32'(overrun), 32'd0);

        // Completion and accept in the same cycle keep word_valid high
        send_word(8'h11, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("b2b_valid", 32'(word_valid), 32'd1);
        chk("b2b_word", 32'(word_out), 32'h7F);
        chk("b2b_no_ovr", 32'(overrun), 32'd0);

        // Reset mid-word discards partial bits
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h02, 1'b0, 1'b0);
        chk("t5_word", 32'(word_out), 32'h02);
        chk("t5_cnt", 32'(ones_count), 32'd1);

        // Randomized stream standing in for the sequence generator's y_out
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/y_stream_deserializer.md
Name: y_stream_deserializer

Overview:
- Downstream consumer of the Mealy sequence-generator output (y_out).
- Collects qualified serial bits into WIDTH-bit words, LSB first, and counts the ones in each word.
- Presents each completed word on a valid/ready handshake, double-buffered so bit collection never stalls.
- Flags a sticky overrun when a completed word cannot be delivered.

Parameters:
- WIDTH, 8, bits per assembled word (legal range 2..32).
- CW, $clog2(WIDTH+1), width of the ones-count field (derived; not overridden).

Ports:
- clock  input  1  rising-edge clock shared with the sequence FSM.
- reset  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data; connects to the FSM's y_out.
- bit_valid  input  1  qualifies bit_in for the current cycle.
- word_ready  input  1  downstream accepts word_out this cycle.
- clr_overrun  input  1  synchronous clear of the overrun flag.
- word_out  output  WIDTH  assembled word; bit 0 is the first bit received.
- ones_count  output  CW  number of 1s in word_out.
- word_valid  output  1  word_out and ones_count hold an undelivered word.
- overrun  output  1  sticky; a completed word was dropped.
- bit_index  output  CW  bits collected into the current partial word (0..WIDTH-1).

Behaviour:
- Reset (reset=1 at a rising edge) clears all state:
  - word_out=0, ones_count=0, word_valid=0, overrun=0, bit_index=0.
  - Shift register and partial ones-count are also cleared.
  - reset overrides every other input in the same cycle.
  - Reset mid-word discards the partial word; a pending output word is discarded too.
- Assembly:
  - On each edge with bit_valid=1, bit_in is written into position bit_index of the shift register, and the partial ones-count increments by bit_in.
  - bit_valid=0 holds all assembly state; idle gaps of any length are allowed.
- Completion:
  - The edge that samples a bit with bit_index=WIDTH-1 completes the word and wraps bit_index to 0.
  - The partial register and partial count restart at 0, so the next bit goes to position 0.
- Output register: two states, EMPTY (word_valid=0) and FULL (word_valid=1).
  - EMPTY, completion: load word_out/ones_count (including the completing bit); go to FULL. word_valid is visible from the edge after the last bit is sampled, giving 1-cycle latency.
  - FULL, word_ready=1, no completion: go to EMPTY. word_out keeps its last value; consumers must ignore it while word_valid=0.
  - FULL, word_ready=1, completion in the same cycle: load the new word and stay FULL. No overrun, no bubble.
  - FULL, word_ready=0, completion: drop the new word, keep the old word, set overrun=1.
  - word_out and ones_count are stable while FULL and word_ready=0.
- overrun:
  - Stays set until clr_overrun=1 or reset.
  - If clr_overrun and a new overrun event occur in the same cycle, overrun ends at 1 (set wins).
- ones_count arithmetic:
  - Unsigned CW bits; maximum value is WIDTH, which never wraps.
  - Must equal the popcount of word_out whenever word_valid=1.
- Throughput: sustains one bit per cycle indefinitely when word_ready is held at 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then bit_valid=1 with bits 1,0,1,1,0,0,0,1 on consecutive cycles and word_ready=0 -> one cycle after the 8th bit: word_valid=1, word_out=8'h8D, ones_count=4, overrun=0, bit_index=0.
- Same 8 bits with bit_valid gapped (valid on alternate cycles) -> identical word 8'h8D and ones_count 4; bit_index advances only on valid cycles.
- Word 8'h8D held unaccepted, then 8 more bits all 1 with word_ready=0 -> word_out stays 8'h8D, overrun=1. Then word_ready=1 for one cycle -> word_valid=0. Then clr_overrun=1 -> overrun=0.
- word_ready tied 1, continuous stream of 24 bits (8'hFF, 8'h00, 8'hA5) -> three valid pulses with ones_count 8, 0, 4; overrun never sets; back-to-back completion-plus-accept keeps word_valid=1 with no gap.
- reset=1 asserted after 5 bits of a word, then 8 fresh bits 0,1,0,0,0,0,0,0 -> word_out=8'h02, ones_count=1 (pre-reset bits discarded).
- FSM integration: sequence FSM with x_in driven as its bench sequence, y_out->bit_in, bit_valid=1 -> captured words match a reference model of y_out packed LSB first, and ones_count matches popcount on every word_valid.
